io_bus_arbiter: RTL
===================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of each requester port.
REQ-002 Parameter DATA_W, 32, data width of each requester port.
REQ-003 Parameter GPIO_W, 8, width of the GPIO output register.
REQ-004 Port clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port m0_req / m1_req  input  1  requester n asks for one IO access.
REQ-007 Port m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-008 Port m0_addr / m1_addr  input  ADDR_W  byte address of the access.
REQ-009 Port m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-010 Port m0_gnt / m1_gnt  output  1  requester n owns the bus (registered).
REQ-011 Port m0_done / m1_done  output  1  one-cycle completion pulse for requester n.
REQ-012 Port rdata  output  DATA_W  read data, valid only in the cycle any done is high.
REQ-013 Port gpio  output  GPIO_W  registered GPIO output value.

Function
REQ-014 FSM states IDLE, ACC, RESP; IDLE SHALL be entered on reset.
REQ-015 IDLE: if any req is high, the arbiter SHALL latch the winner's we/addr/wdata, assert its gnt, and go to ACC next cycle.
REQ-016 ACC: the access SHALL be performed on the latched fields; go to RESP.
REQ-017 RESP: the winner's done SHALL be high for exactly this cycle together with rdata; gnt SHALL deassert; go to IDLE.
REQ-018 Latency: req sampled in cycle T -> done in cycle T+2; next grant no earlier than T+3.
REQ-019 Both req high in IDLE: round-robin; the requester not granted last SHALL win; after reset m0 has priority.
REQ-020 At most one gnt and one done SHALL be high in any cycle.
REQ-021 req dropping after grant SHALL NOT abort; the access completes and done still pulses.
REQ-022 Register map (addr[3:0], upper bits ignored): 0x0 GPIO (R/W, low GPIO_W bits, upper read bits 0); 0x4 ID (RO, 32'h4750_494F).
REQ-023 A write to 0x0 SHALL update gpio in the ACC cycle (visible at RESP).
REQ-024 Writes to 0x4 or unmapped offsets SHALL be ignored; unmapped reads SHALL return 0.
REQ-025 Outside RESP, rdata SHALL be driven 0.

Reset
REQ-026 On rst: state IDLE, gnt/done 0, rdata 0, gpio 0, round-robin pointer favours m0.
REQ-027 rst in ACC or RESP SHALL abort the transaction: no done pulse, and no gpio write if asserted in ACC.

Configuration
REQ-028 Macro IO_ARB_FIXED_PRIO_EN defined: m0 SHALL always win simultaneous requests and the pointer SHALL be removed.
REQ-029 Macro undefined: round-robin per REQ-019.

Structure
REQ-030 Package io_bus_pkg SHALL hold the FSM state typedef, register offsets, and the ID constant.
REQ-031 Sub-module io_rr_picker SHALL implement the 2-way winner selection and pointer update.

Verification
REQ-032 Reset, then m0 writes 0x0 data 0xA5 -> m0_gnt at T+1, m0_done at T+2, gpio = 8'hA5.
REQ-033 m0 and m1 both request in the same cycle, m1 writes 0x0 data 0x3C -> m0 served first, then m1, gpio ends 8'h3C; with IO_ARB_FIXED_PRIO_EN and both held, m0 is served repeatedly.
REQ-034 m1 reads 0x4 -> rdata = 32'h4750_494F during m1_done; read of 0x8 -> rdata 0.
REQ-035 m0 drops req one cycle after grant -> m0_done still pulses at T+2.
REQ-036 rst asserted during ACC of a write of 0xFF -> no done pulse, gpio = 0, FSM in IDLE.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the two-requester IO bus arbiter.
// Build option: IO_ARB_FIXED_PRIO_EN selects fixed m0 priority instead of round-robin.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int          OFFS_W   = 4;
    localparam logic [3:0]  REG_GPIO = 4'h0;
    localparam logic [3:0]  REG_ID   = 4'h4;
    localparam logic [31:0] ID_VALUE = 32'h4750_494F;

    // Requester index (0 = m0, 1 = m1) to its one-hot strobe pair.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two requesters and the arbiter; master = requester side.
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int GPIO_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;

    logic [DATA_W-1:0] rdata;
    logic [GPIO_W-1:0] gpio;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_gnt, m0_done, m1_gnt, m1_done, rdata, gpio
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_gnt, m0_done, m1_gnt, m1_done, rdata, gpio
    );
endinterface

// File: rtl/io_rr_picker.sv
// Two-way winner selection for the IO bus arbiter.
// IO_ARB_FIXED_PRIO_EN: m0 always wins and the round-robin pointer is removed.
module io_rr_picker (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       winner_o
);
`ifdef IO_ARB_FIXED_PRIO_EN
    logic unused_ports;

    assign winner_o     = req_i[0] ? 1'b0 : req_i[1];
    assign unused_ports = ^{clk, rst, grant_en_i};
`else
    // prio_q names the requester that wins a tie; it flips away from every winner.
    logic prio_q, prio_d;

    always_comb begin
        winner_o = (&req_i) ? prio_q : req_i[1];
        prio_d   = grant_en_i ? ~winner_o : prio_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif
endmodule

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter fronting a tiny register block (GPIO + ID); one access at a time.
// IO_ARB_FIXED_PRIO_EN (in io_rr_picker) switches ties from round-robin to fixed m0 priority.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int GPIO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    io_bus_arbiter_if.slave bus
);
    state_e              state_q, state_d;
    logic [1:0]          req;
    logic                start;
    logic                winner;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                unused_bits;

    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [OFFS_W-1:0]   offs_q, offs_d;
    logic [GPIO_W-1:0]   wdata_q, wdata_d;

    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   rd_val;
    logic [GPIO_W-1:0]   gpio_q, gpio_d;

    assign req   = {bus.m1_req, bus.m0_req};
    assign start = (state_q == ST_IDLE) && (|req);

    io_rr_picker u_picker (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .grant_en_i (start),
        .winner_o   (winner)
    );

    assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

    // Only the register offset and the GPIO-wide slice of write data are decoded.
    assign unused_bits = ^{sel_addr[ADDR_W-1:OFFS_W], sel_wdata[DATA_W-1:GPIO_W]};

    always_comb begin
        rd_val = '0;
        case (offs_q)
            REG_GPIO: rd_val[GPIO_W-1:0] = gpio_q;
            REG_ID:   rd_val = DATA_W'(ID_VALUE);
            default:  rd_val = '0;
        endcase
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        offs_d  = offs_q;
        wdata_d = wdata_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = '0;
        gpio_d  = gpio_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    owner_d = winner;
                    we_d    = sel_we;
                    offs_d  = sel_addr[OFFS_W-1:0];
                    wdata_d = sel_wdata[GPIO_W-1:0];
                    gnt_d   = req_onehot(winner);
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                done_d  = req_onehot(owner_q);
                state_d = ST_RESP;
                if (we_q) begin
                    if (offs_q == REG_GPIO) begin
                        gpio_d = wdata_q;
                    end
                end else begin
                    rdata_d = rd_val;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            gpio_q  <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            owner_q <= owner_d;
        end
    end

    // NOTE: latched request fields carry no reset; they are only consumed in
    // ACC, which is always entered through IDLE where they are loaded.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        offs_q  <= offs_d;
        wdata_q <= wdata_d;
    end

    assign bus.m0_gnt = gnt_q[0];
    assign bus.m1_gnt = gnt_q[1];
    // A reset raised during RESP suppresses the completion pulse in that same cycle.
    assign bus.m0_done = done_q[0] & ~rst;
    assign bus.m1_done = done_q[1] & ~rst;
    assign bus.rdata   = rst ? '0 : rdata_q;
    assign bus.gpio    = gpio_q;

endmodule
